// File: rtl/search_mc_pkg.sv
// Shared types and constants for the multicorner capture/monitor stage.
package search_mc_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_TS_W  = 8;
  localparam int unsigned DEF_CNT_W = 16;
  // Widest timestamp the packing helper supports.
  localparam int unsigned MAX_TS_W  = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Pack one event as {sample[1:0], ts[ts_w-1:0]}, right-aligned.
  function automatic logic [MAX_TS_W+1:0] pack_entry(input logic [1:0] sample,
                                                     input logic [MAX_TS_W-1:0] ts,
                                                     input int unsigned ts_w);
    logic [MAX_TS_W+1:0] s_w;
    logic [MAX_TS_W+1:0] t_w;
    s_w = (MAX_TS_W+2)'(sample) << ts_w;
    t_w = (MAX_TS_W+2)'(ts);
    return s_w | t_w;
  endfunction

endpackage

// File: rtl/search_mc_capture_if.sv
// Capture inputs and event read port of the capture stage.
interface search_mc_capture_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             en;
  logic             d1;
  logic             d2;
  logic             rd_ready;
  logic             rd_valid;
  logic [TS_W+1:0]  rd_data;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] event_cnt;
  logic             overflow;

  modport master (
    output en, d1, d2, rd_ready,
    input  rd_valid, rd_data, level, event_cnt, overflow
  );

  modport slave (
    input  en, d1, d2, rd_ready,
    output rd_valid, rd_data, level, event_cnt, overflow
  );
endinterface

// File: rtl/search_mc_fifo.sv
// First-word-fall-through event FIFO; push while full is accepted only with a pop.
module search_mc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [LVL_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];
  assign level   = cnt;

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LVL_W'(1);
        2'b01:   cnt <= cnt - LVL_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/search_mc_capture.sv
// Capture the two path outputs, timestamp every change, queue events for readout.
module search_mc_capture
  import search_mc_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  search_mc_capture_if.slave bus
);
  localparam int unsigned ENT_W = TS_W + 2;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cap;
  logic [1:0]       prev;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] event_cnt;
  logic             overflow;
  logic             push_c;
  logic             pop_c;
  logic             full;
  logic             empty;
  logic [ENT_W-1:0] entry_c;

  assign entry_c      = ENT_W'(pack_entry(cap, MAX_TS_W'(ts), TS_W));
  assign pop_c        = bus.rd_ready & ~empty;
  assign bus.rd_valid = ~empty;
  assign bus.event_cnt = event_cnt;
  assign bus.overflow  = overflow;

  // Next state and change detection; PRIME absorbs the first sample so enabling never fires.
  always_comb begin
    state_nxt = state;
    push_c    = 1'b0;
    case (state)
      IDLE:    if (bus.en) state_nxt = PRIME;
      PRIME:   state_nxt = bus.en ? RUN : IDLE;
      RUN: begin
        if (!bus.en) state_nxt = IDLE;
        else         push_c    = (cap != prev);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sample capture, timestamp, saturating event count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap       <= '0;
      prev      <= '0;
      ts        <= '0;
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      cap <= {bus.d2, bus.d1};
      if (state != IDLE) prev <= cap;
      ts <= (state == IDLE) ? '0 : ts + TS_W'(1);
      if (push_c && (event_cnt != '1)) event_cnt <= event_cnt + CNT_W'(1);
      if (push_c && full && !pop_c)    overflow  <= 1'b1;
    end
  end

  search_mc_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (bus.rd_ready),
    .wdata (entry_c),
    .rdata (bus.rd_data),
    .full  (full),
    .empty (empty),
    .level (bus.level)
  );

endmodule

// File: doc/search_mc_capture.md
Name: search_mc_capture

Overview:
- Downstream capture/monitor stage for the multicorner register-pair path; consumes the two path outputs (registered-path output and direct-buffer output) on the same clock.
- Registers both bits every cycle, detects any change of the 2-bit sample, and timestamps each change.
- Queues change events in a small FIFO drained through a valid/ready read port; keeps a saturating event count and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- TS_W, 8, timestamp counter width
- CNT_W, 16, event counter width

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable
- d1  input  1  sample of registered-path output
- d2  input  1  sample of direct-buffer output
- rd_ready  input  1  consumer accepts head entry
- rd_valid  output  1  FIFO non-empty
- rd_data  output  TS_W+2  head entry: [TS_W+1]=d2, [TS_W]=d1, [TS_W-1:0]=timestamp
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- event_cnt  output  CNT_W  detected changes, saturating
- overflow  output  1  sticky: a change was dropped because FIFO was full

Behaviour:
- Reset (rst=1 at edge): state=IDLE; cap, prev, ts, event_cnt, level, FIFO pointers = 0; rd_valid=0, rd_data=0, overflow=0. Takes priority over every other event, including a push or pop in the same cycle.
- cap <= {d2,d1} on every non-reset edge, regardless of state.
- States:
  - IDLE: en=1 -> PRIME.
  - PRIME: prev <= cap, no push; en=1 -> RUN, en=0 -> IDLE.
  - RUN: prev <= cap; en=0 -> IDLE (no push that edge).
- ts: cleared in IDLE; increments by 1 each edge in PRIME/RUN; wraps 2^TS_W-1 -> 0.
- Change detect: in RUN with en=1, cap != prev raises push. The pushed entry is {cap, ts} using pre-increment values.
- Latency: d change before edge k is captured at edge k and written at edge k+1; rd_valid=1 after edge k+1.
- event_cnt: +1 per push request, including dropped ones; holds at 2^CNT_W-1.
- FIFO:
  - pop = rd_valid & rd_ready; rd_data is first-word-fall-through (head visible while rd_valid=1).
  - rd_data is 0 when empty.
  - Full & push & !pop: entry dropped, overflow <= 1 until rst.
  - Full & push & pop: both happen, level unchanged, no overflow.
  - Empty & pop: impossible (rd_valid=0).
  - Pointers wrap modulo DEPTH.
- Deasserting en does not flush the FIFO; draining continues in IDLE.

Decomposition:
- Package search_mc_pkg holds:
  - state enum {IDLE, PRIME, RUN}
  - default width constants
  - entry packing helper/struct {sample[1:0], ts}
- One sub-module, search_mc_fifo (DEPTH x (TS_W+2), FWFT, push/pop/full/empty/level). The top holds the FSM, capture regs, ts, counters and overflow.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1 and toggling d1 -> all outputs 0, state IDLE; a rst pulse mid-RUN with 3 entries queued -> level=0, rd_valid=0, overflow=0 next cycle.
- Basic capture: en=1 at cycle 0, d1 rises before edge 5 -> rd_valid at edge 6, rd_data={2'b01, ts=4}, event_cnt=1; rd_ready=1 pops it, level=0.
- No spurious event on enable: d1=d2=1 constant, en rises -> PRIME absorbs the value, event_cnt stays 0 over 20 cycles.
- Overflow: rd_ready=0, 5 toggles of d2 in RUN (DEPTH=4) -> level=4, event_cnt=5, overflow=1, the 4 entries kept in order; overflow stays 1 after draining.
- Simultaneous push/pop at full: level=4, rd_ready=1 on the same cycle as a change -> level stays 4, overflow=0, new entry at tail.
- Wrap/saturation (TS_W=3, CNT_W=3): 9+ toggles spaced 3 cycles apart -> timestamps wrap 7->0, event_cnt holds at 7.
